// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multicycle RV32I core.
// Sequences the shared ALU, the unified memory port and the register file,
// stalls on memory wait states and counts retired instructions.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op, funct3_0        opcode and funct3[0] of the instruction register
//   zero, mem_ready     ALU zero flag, memory access completes this cycle
//   PCWrite..RegWrite   datapath strobes and 1-bit selects
//   ResultSrc..ImmSrc   datapath 2-bit selects
//   retire, instret     completion pulse and retired-instruction count
//   trap, state_o       sticky illegal-opcode flag, current state
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             funct3_0,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [3:0]       state_o
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic             r_trap;
  logic             w_pcw, w_mw, w_irw, w_rw, w_ret;

  always_comb begin
    w_next    = r_state;
    w_pcw     = 1'b0;
    w_mw      = 1'b0;
    w_irw     = 1'b0;
    w_rw      = 1'b0;
    w_ret     = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = mem_ready;
        w_pcw     = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
        w_ret     = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mw   = 1'b1;
        w_ret  = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw   = 1'b1;
        w_ret  = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        w_pcw   = zero ^ funct3_0;
        w_ret   = 1'b1;
        w_next  = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pcw   = 1'b1;
        w_next  = S_ALUWB;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BR:       ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  // Write strobes and retire are masked during reset so an aborted
  // instruction leaves no architectural side effect.
  assign PCWrite  = w_pcw & ~rst;
  assign MemWrite = w_mw  & ~rst;
  assign IRWrite  = w_irw & ~rst;
  assign RegWrite = w_rw  & ~rst;
  assign retire   = w_ret & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
      r_trap    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_trap  <= (w_next == S_TRAP);
      if (w_ret) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret = r_instret;
  assign trap    = r_trap;
  assign state_o = r_state;

endmodule
